// File: rtl/move_command_ir_transmitter_pkg.sv
// Shared definitions for the rover move-command IR link.
// The transmitter FSM state encoding, the command field layout and the default
// frame timing live here. The rover-side receiver uses the same constants.
package move_command_ir_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_MARK = 3'd1,
        BIT_SPACE  = 3'd2,
        BIT_MARK   = 3'd3,
        FRAME_GAP  = 3'd4
    } state_t;

    // Command layout: angle [11:7], distance [6:0]
    localparam int CMD_WIDTH = 12;
    localparam int ANGLE_MSB = 11;
    localparam int ANGLE_LSB = 7;
    localparam int DIST_MSB  = 6;
    localparam int DIST_LSB  = 0;

    // Default timing at 27 MHz: 600 us unit, ~40 kHz carrier
    localparam int DEF_UNIT_CYCLES         = 16200;
    localparam int DEF_CARRIER_HALF_PERIOD = 338;
    localparam int DEF_START_UNITS         = 4;
    localparam int DEF_ZERO_UNITS          = 1;
    localparam int DEF_ONE_UNITS           = 2;
    localparam int DEF_SPACE_UNITS         = 1;
    localparam int DEF_GAP_UNITS           = 10;
    localparam int DEF_REPEATS             = 3;

    // Width of a counter running 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/move_command_ir_transmitter_if.sv
// Handshake and output bundle between the path/orientation FSM (master) and
// the IR transmitter (slave).
//   send        master->slave  one-cycle request strobe
//   command     master->slave  12-bit move command
//   busy        slave->master  transfer in progress
//   done        slave->master  one-cycle completion pulse
//   ir_envelope slave->master  unmodulated mark/space
//   ir_out      slave->master  carrier-gated LED drive
//   state       slave->master  FSM state for debug
interface move_command_ir_transmitter_if;
    import move_command_ir_transmitter_pkg::*;

    logic                 send;
    logic [CMD_WIDTH-1:0] command;
    logic                 busy;
    logic                 done;
    logic                 ir_envelope;
    logic                 ir_out;
    state_t               state;

    modport master (
        output send, command,
        input  busy, done, ir_envelope, ir_out, state
    );

    modport slave (
        input  send, command,
        output busy, done, ir_envelope, ir_out, state
    );

endinterface

// File: rtl/move_command_ir_transmitter_ir_carrier_gen.sv
// IR carrier generator: a half-period counter that toggles the carrier on wrap.
// restart forces the carrier high and the counter to zero so every mark
// begins with a full high half-period.
//   clock    in   system clock
//   reset    in   synchronous, active-high
//   restart  in   high in the cycle before a mark begins
//   carrier  out  carrier level for the coming cycle; the top registers
//                 ir_out from it on the same edge as the envelope
module ir_carrier_gen
    import move_command_ir_transmitter_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_CARRIER_HALF_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic carrier
);

    localparam int CW = cnt_width(HALF_PERIOD);

    logic [CW-1:0] r_count;
    logic          r_carrier;
    logic [CW-1:0] w_count_next;

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        w_count_next = r_count + CW'(1);
        carrier      = r_carrier;
        if (restart) begin
            w_count_next = '0;
            carrier      = 1'b1;
        end else if (r_count == CW'(HALF_PERIOD - 1)) begin
            w_count_next = '0;
            carrier      = ~r_carrier;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_carrier <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_carrier <= carrier;
        end
    end

endmodule

// File: rtl/move_command_ir_transmitter.sv
// Rover move-command IR transmitter.
// Latches a 12-bit command on send and emits it REPEATS times as a
// pulse-width frame: start mark, then per bit (LSB first) a space followed by
// a short (0) or long (1) mark, then a trailing gap. Marks are gated by the
// IR carrier.
//   clock  in      system clock
//   reset  in      synchronous, active-high
//   link   slave   send/command in; busy/done/ir_envelope/ir_out/state out
module move_command_ir_transmitter
    import move_command_ir_transmitter_pkg::*;
#(
    parameter int UNIT_CYCLES         = DEF_UNIT_CYCLES,
    parameter int CARRIER_HALF_PERIOD = DEF_CARRIER_HALF_PERIOD,
    parameter int START_UNITS         = DEF_START_UNITS,
    parameter int ZERO_UNITS          = DEF_ZERO_UNITS,
    parameter int ONE_UNITS           = DEF_ONE_UNITS,
    parameter int SPACE_UNITS         = DEF_SPACE_UNITS,
    parameter int GAP_UNITS           = DEF_GAP_UNITS,
    parameter int REPEATS             = DEF_REPEATS
) (
    input logic clock,
    input logic reset,
    move_command_ir_transmitter_if.slave link
);

    localparam int UW = cnt_width(UNIT_CYCLES);
    localparam int MAX_UNITS = max_int(max_int(max_int(START_UNITS, SPACE_UNITS),
                                               max_int(ZERO_UNITS, ONE_UNITS)), GAP_UNITS);
    localparam int PW = cnt_width(MAX_UNITS);
    localparam int RW = cnt_width(REPEATS);
    localparam int IW = cnt_width(CMD_WIDTH);

    state_t               r_state;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [UW-1:0]        r_unit_cnt;
    logic [PW-1:0]        r_phase_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [RW-1:0]        r_rep_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_envelope;
    logic                 r_ir_out;

    state_t               w_state_next;
    logic [CMD_WIDTH-1:0] w_cmd_next;
    logic [UW-1:0]        w_unit_next;
    logic [PW-1:0]        w_phase_next;
    logic [IW-1:0]        w_idx_next;
    logic [RW-1:0]        w_rep_next;
    logic                 w_done_next;
    logic                 w_env_next;
    logic                 w_restart;
    logic                 w_carrier_next;
    logic [PW-1:0]        w_phase_last;
    logic                 w_unit_last;
    logic                 w_phase_end;

    // Index of the last unit of the current phase
    always_comb begin
        w_phase_last = '0;
        case (r_state)
            START_MARK: w_phase_last = PW'(START_UNITS - 1);
            BIT_SPACE:  w_phase_last = PW'(SPACE_UNITS - 1);
            BIT_MARK:   w_phase_last = r_cmd[r_bit_idx] ? PW'(ONE_UNITS - 1) : PW'(ZERO_UNITS - 1);
            FRAME_GAP:  w_phase_last = PW'(GAP_UNITS - 1);
            default:    w_phase_last = '0;
        endcase
    end

    assign w_unit_last = (r_unit_cnt == UW'(UNIT_CYCLES - 1));
    // True on the final cycle of a phase; the transition happens on the edge that ends it
    assign w_phase_end = (r_state != IDLE) && w_unit_last && (r_phase_cnt == w_phase_last);

    always_comb begin
        w_state_next = r_state;
        w_cmd_next   = r_cmd;
        w_unit_next  = w_unit_last ? '0 : r_unit_cnt + UW'(1);
        w_phase_next = w_unit_last ? r_phase_cnt + PW'(1) : r_phase_cnt;
        w_idx_next   = r_bit_idx;
        w_rep_next   = r_rep_cnt;
        w_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                w_unit_next  = '0;
                w_phase_next = '0;
                if (link.send) begin
                    w_cmd_next   = link.command;
                    w_idx_next   = '0;
                    w_rep_next   = '0;
                    w_state_next = START_MARK;
                end
            end
            START_MARK: if (w_phase_end) w_state_next = BIT_SPACE;
            BIT_SPACE:  if (w_phase_end) w_state_next = BIT_MARK;
            BIT_MARK: begin
                if (w_phase_end) begin
                    if (r_bit_idx < IW'(CMD_WIDTH - 1)) begin
                        w_idx_next   = r_bit_idx + IW'(1);
                        w_state_next = BIT_SPACE;
                    end else begin
                        w_state_next = FRAME_GAP;
                    end
                end
            end
            FRAME_GAP: begin
                if (w_phase_end) begin
                    if (r_rep_cnt < RW'(REPEATS - 1)) begin
                        w_rep_next   = r_rep_cnt + RW'(1);
                        w_idx_next   = '0;
                        w_state_next = START_MARK;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_phase_end) begin
            w_unit_next  = '0;
            w_phase_next = '0;
        end
    end

    // Marks never follow marks directly, so a mark state differing from the
    // current one is always the entry edge of a new mark
    assign w_env_next = (w_state_next == START_MARK) || (w_state_next == BIT_MARK);
    assign w_restart  = w_env_next && (w_state_next != r_state);

    ir_carrier_gen #(
        .HALF_PERIOD (CARRIER_HALF_PERIOD)
    ) u_carrier (
        .clock   (clock),
        .reset   (reset),
        .restart (w_restart),
        .carrier (w_carrier_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_unit_cnt  <= '0;
            r_phase_cnt <= '0;
            r_bit_idx   <= '0;
            r_rep_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_envelope  <= 1'b0;
            r_ir_out    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd       <= w_cmd_next;
            r_unit_cnt  <= w_unit_next;
            r_phase_cnt <= w_phase_next;
            r_bit_idx   <= w_idx_next;
            r_rep_cnt   <= w_rep_next;
            r_busy      <= (w_state_next != IDLE);
            r_done      <= w_done_next;
            r_envelope  <= w_env_next;
            r_ir_out    <= w_env_next & w_carrier_next;
        end
    end

    assign link.busy        = r_busy;
    assign link.done        = r_done;
    assign link.ir_envelope = r_envelope;
    assign link.ir_out      = r_ir_out;
    assign link.state       = r_state;

endmodule

// File: tb/tb_move_command_ir_transmitter.sv
// Self-checking bench for move_command_ir_transmitter.
// Two instances share clock, reset and stimulus: dut_a with REPEATS=1 and
// dut_b with REPEATS=3, both with UNIT_CYCLES=4 and CARRIER_HALF_PERIOD=2.
// Edge k is the k-th rising clock edge after the one at which send is driven;
// outputs are sampled 1 time unit after each edge.
module tb_move_command_ir_transmitter;
    import move_command_ir_transmitter_pkg::*;

    localparam int U    = 4;
    localparam int H    = 2;
    localparam int MAXC = 600;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    move_command_ir_transmitter_if if_a ();
    move_command_ir_transmitter_if if_b ();

    move_command_ir_transmitter #(
        .UNIT_CYCLES (U), .CARRIER_HALF_PERIOD (H), .REPEATS (1)
    ) dut_a (
        .clock (clock), .reset (reset), .link (if_a)
    );

    move_command_ir_transmitter #(
        .UNIT_CYCLES (U), .CARRIER_HALF_PERIOD (H), .REPEATS (3)
    ) dut_b (
        .clock (clock), .reset (reset), .link (if_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic   cap_env   [2][MAXC];
    logic   cap_ir    [2][MAXC];
    logic   cap_busy  [2][MAXC];
    logic   cap_done  [2][MAXC];
    state_t cap_state [2][MAXC];

    logic exp_env  [MAXC];
    logic exp_ir   [MAXC];
    logic exp_busy [MAXC];
    logic exp_done [MAXC];
    int   m_pos;

    typedef struct {
        logic [11:0] cmd;
        int          done_edge;
        int          rises;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic snd, input logic [11:0] cmd);
        if_a.send    = snd;
        if_a.command = cmd;
        if_b.send    = snd;
        if_b.command = cmd;
    endtask

    task automatic sample(input int k);
        cap_env[0][k]   = if_a.ir_envelope;
        cap_ir[0][k]    = if_a.ir_out;
        cap_busy[0][k]  = if_a.busy;
        cap_done[0][k]  = if_a.done;
        cap_state[0][k] = if_a.state;
        cap_env[1][k]   = if_b.ir_envelope;
        cap_ir[1][k]    = if_b.ir_out;
        cap_busy[1][k]  = if_b.busy;
        cap_done[1][k]  = if_b.done;
        cap_state[1][k] = if_b.state;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_inputs(1'b0, 12'h000);
        repeat (2) @(posedge clock);
        #1;
        check("reset state",       if_a.state, IDLE);
        check("reset busy",        if_a.busy, 0);
        check("reset done",        if_a.done, 0);
        check("reset ir_envelope", if_a.ir_envelope, 0);
        check("reset ir_out",      if_a.ir_out, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Drives send with cmd now (edge 0) and captures edges 1..ncyc.
    // Optional: a second send at send2_edge switching command to cmd2 (held),
    // a third send at send3_edge, and a one-cycle reset at rst_edge (-1 = none).
    task automatic run(input logic [11:0] cmd, input int ncyc, input int send2_edge,
                       input logic [11:0] cmd2, input int send3_edge, input int rst_edge);
        logic [11:0] cur;
        cur = cmd;
        sample(0);
        set_inputs(1'b1, cur);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock);
            #1;
            sample(k);
            if (k == send2_edge) cur = cmd2;
            set_inputs((k == send2_edge) || (k == send3_edge), cur);
            reset = (k == rst_edge);
        end
        set_inputs(1'b0, cur);
        reset = 1'b0;
    endtask

    // Behavioural frame model: a flat list of mark/space runs
    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) begin
            exp_env[k]  = 1'b0;
            exp_ir[k]   = 1'b0;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
        end
    endtask

    task automatic put(input logic lvl, input int len);
        for (int p = 0; p < len; p++) begin
            if (m_pos < MAXC) begin
                exp_env[m_pos]  = lvl;
                exp_ir[m_pos]   = lvl && (((p / H) % 2) == 0);
                exp_busy[m_pos] = 1'b1;
            end
            m_pos++;
        end
    endtask

    task automatic model_add(input logic [11:0] cmd, input int reps, input int send_edge,
                             output int done_edge);
        m_pos = send_edge + 1;
        for (int r = 0; r < reps; r++) begin
            put(1'b1, DEF_START_UNITS * U);
            for (int i = 0; i < 12; i++) begin
                put(1'b0, DEF_SPACE_UNITS * U);
                put(1'b1, (cmd[i] ? DEF_ONE_UNITS : DEF_ZERO_UNITS) * U);
            end
            put(1'b0, DEF_GAP_UNITS * U);
        end
        done_edge = m_pos;
        if (m_pos < MAXC) exp_done[m_pos] = 1'b1;
    endtask

    task automatic compare(input int d, input string tag, input int ncyc);
        int be, bi, bb, bd, first;
        be = 0; bi = 0; bb = 0; bd = 0; first = -1;
        for (int k = 1; k <= ncyc; k++) begin
            if (cap_env[d][k]  !== exp_env[k])  be++;
            if (cap_ir[d][k]   !== exp_ir[k])   bi++;
            if (cap_busy[d][k] !== exp_busy[k]) bb++;
            if (cap_done[d][k] !== exp_done[k]) bd++;
            if (first < 0 && (cap_env[d][k] !== exp_env[k] || cap_ir[d][k] !== exp_ir[k] ||
                              cap_busy[d][k] !== exp_busy[k] || cap_done[d][k] !== exp_done[k]))
                first = k;
        end
        check($sformatf("%s envelope bad cycles (first bad edge %0d)", tag, first), be, 0);
        check($sformatf("%s ir_out bad cycles (first bad edge %0d)", tag, first), bi, 0);
        check($sformatf("%s busy bad cycles (first bad edge %0d)", tag, first), bb, 0);
        check($sformatf("%s done bad cycles (first bad edge %0d)", tag, first), bd, 0);
    endtask

    // Decodes mark runs: first run is the start mark, next 12 are bits by length
    task automatic decode(input int d, input int from, input int to,
                          output int rises, output logic [11:0] bits);
        int run_len;
        logic prev;
        rises = 0; bits = '0; run_len = 0; prev = 1'b0;
        for (int k = from; k <= to + 1; k++) begin
            logic v;
            v = (k <= to) ? cap_env[d][k] : 1'b0;
            if (v && !prev) rises++;
            if (v) run_len++;
            if (!v && prev) begin
                if (rises >= 2 && rises <= 13) bits[rises - 2] = (run_len > DEF_ZERO_UNITS * U);
                run_len = 0;
            end
            prev = v;
        end
    endtask

    task automatic find_done(input int d, input int from, input int to,
                             output int first, output int count);
        first = -1; count = 0;
        for (int k = from; k <= to; k++) begin
            if (cap_done[d][k] === 1'b1) begin
                if (first < 0) first = k;
                count++;
            end
        end
    endtask

    initial begin
        int          de, first, cnt, rises;
        logic [11:0] bits;
        logic [11:0] rcmd;

        vecs[0] = '{cmd: 12'h005, done_edge: 161, rises: 13};
        vecs[1] = '{cmd: 12'h000, done_edge: 153, rises: 13};
        vecs[2] = '{cmd: 12'hFFF, done_edge: 201, rises: 13};
        vecs[3] = '{cmd: 12'h0A3, done_edge: 169, rises: 13};

        set_inputs(1'b0, 12'h000);

        // Table-driven single frames
        for (int i = 0; i < 4; i++) begin
            do_reset();
            run(vecs[i].cmd, 215, -1, 12'h000, -1, -1);
            model_clear();
            model_add(vecs[i].cmd, 1, 0, de);
            compare(0, $sformatf("cmd %03h", vecs[i].cmd), 215);
            find_done(0, 1, 215, first, cnt);
            check($sformatf("cmd %03h done edge", vecs[i].cmd), first, vecs[i].done_edge);
            check($sformatf("cmd %03h done count", vecs[i].cmd), cnt, 1);
            check($sformatf("cmd %03h busy at done edge", vecs[i].cmd), cap_busy[0][vecs[i].done_edge], 0);
            decode(0, 1, vecs[i].done_edge - 1, rises, bits);
            check($sformatf("cmd %03h envelope rises", vecs[i].cmd), rises, vecs[i].rises);
            check($sformatf("cmd %03h decoded bits", vecs[i].cmd), bits, vecs[i].cmd);
            if (i == 0) begin
                check("0x005 state edge 0",   cap_state[0][0],   IDLE);
                check("0x005 state edge 1",   cap_state[0][1],   START_MARK);
                check("0x005 env edge 16",    cap_env[0][16],    1);
                check("0x005 state edge 17",  cap_state[0][17],  BIT_SPACE);
                check("0x005 state edge 21",  cap_state[0][21],  BIT_MARK);
                check("0x005 state edge 121", cap_state[0][121], FRAME_GAP);
                check("0x005 state edge 161", cap_state[0][161], IDLE);
            end
        end

        // Random commands against the model
        for (int i = 0; i < 3; i++) begin
            rcmd = 12'($urandom);
            do_reset();
            run(rcmd, 215, -1, 12'h000, -1, -1);
            model_clear();
            model_add(rcmd, 1, 0, de);
            compare(0, $sformatf("random cmd %03h", rcmd), 215);
            find_done(0, 1, 215, first, cnt);
            check($sformatf("random cmd %03h done edge", rcmd), first, de);
            decode(0, 1, de - 1, rises, bits);
            check($sformatf("random cmd %03h decoded bits", rcmd), bits, rcmd);
        end

        // Send while busy is ignored; send on the done cycle starts a new frame
        do_reset();
        run(12'h0A3, 380, 20, 12'hFFF, 169, -1);
        model_clear();
        model_add(12'h0A3, 1, 0, de);
        model_add(12'hFFF, 1, 169, de);
        compare(0, "busy protect", 380);
        find_done(0, 1, 169, first, cnt);
        check("busy protect first done edge", first, 169);
        check("busy protect done count first frame", cnt, 1);
        decode(0, 1, 168, rises, bits);
        check("busy protect first frame bits", bits, 12'h0A3);
        check("busy protect restart envelope edge 170", cap_env[0][170], 1);
        decode(0, 170, 369, rises, bits);
        check("busy protect second frame bits", bits, 12'hFFF);
        find_done(0, 170, 380, first, cnt);
        check("busy protect second done edge", first, 370);

        // Three repeats on dut_b
        do_reset();
        run(12'h005, 490, -1, 12'h000, -1, -1);
        model_clear();
        model_add(12'h005, 3, 0, de);
        compare(1, "repeats", 490);
        find_done(1, 1, 490, first, cnt);
        check("repeats done edge", first, 481);
        check("repeats done count", cnt, 1);
        for (int f = 0; f < 3; f++) begin
            decode(1, 1 + 160 * f, 160 * (f + 1), rises, bits);
            check($sformatf("repeats frame %0d bits", f), bits, 12'h005);
        end

        // Reset mid-frame, then a clean transfer without any other reset
        do_reset();
        run(12'h005, 200, -1, 12'h000, -1, 50);
        model_clear();
        model_add(12'h005, 1, 0, de);
        for (int k = 51; k < MAXC; k++) begin
            exp_env[k] = 1'b0; exp_ir[k] = 1'b0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
        end
        compare(0, "mid-frame reset", 200);
        check("mid-frame reset state edge 51", cap_state[0][51], IDLE);
        check("mid-frame reset busy edge 51", cap_busy[0][51], 0);
        check("mid-frame reset env edge 51", cap_env[0][51], 0);
        find_done(0, 1, 200, first, cnt);
        check("mid-frame reset done count", cnt, 0);

        run(12'h005, 170, -1, 12'h000, -1, -1);
        model_clear();
        model_add(12'h005, 1, 0, de);
        compare(0, "after reset", 170);
        find_done(0, 1, 170, first, cnt);
        check("after reset done edge", first, 161);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/move_command_ir_transmitter.md
Name: move_command_ir_transmitter

Overview:
- Transmitter end of the rover move-command link. Accepts a 12-bit move command (angle [11:7], distance [6:0]) from the path/orientation logic on a one-cycle send strobe.
- Serializes the command LSB-first in a pulse-width frame: start mark, then per bit a space followed by a short mark (0) or long mark (1), then a trailing gap.
- Gates all marks with an IR carrier and repeats the frame REPEATS times.
- Sits between the orientation/path FSM and the IR LED driver pin.

Parameters:
- UNIT_CYCLES, 16200, clock cycles per timing unit (600 us at 27 MHz).
- CARRIER_HALF_PERIOD, 338, clock cycles per carrier half-period (~40 kHz at 27 MHz).
- START_UNITS, 4, start-mark length in units.
- ZERO_UNITS, 1, mark length in units for a 0 bit.
- ONE_UNITS, 2, mark length in units for a 1 bit.
- SPACE_UNITS, 1, space length in units before each bit mark.
- GAP_UNITS, 10, trailing space in units after the last bit of each frame.
- REPEATS, 3, number of identical frames per send.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- send  in  1  one-cycle request strobe; honoured only when idle
- command  in  12  move command; angle [11:7], distance [6:0]
- busy  out  1  high from the cycle after an accepted send until done
- done  out  1  one-cycle pulse when the final frame's gap ends
- ir_envelope  out  1  unmodulated mark (1) / space (0)
- ir_out  out  1  ir_envelope AND carrier; drives the LED
- state  out  3  FSM state, exposed for debug

Behaviour:
- Reset values: busy=0, done=0, ir_envelope=0, ir_out=0, state=IDLE. The command latch, unit counter, phase counter, bit index, repeat counter and carrier all clear to 0.
- States: IDLE, START_MARK, BIT_SPACE, BIT_MARK, FRAME_GAP. All outputs are registered.
- IDLE:
  - done=0 except on the pulse cycle.
  - send=1 latches command, sets bit index 0 and repeat count 0, and moves to START_MARK.
  - Latency: send at edge N gives busy=1 and ir_envelope=1 at edge N+1.
- Unit timing: a unit counter runs 0..UNIT_CYCLES-1. A phase counter counts completed units. Each phase lasts exactly (phase units × UNIT_CYCLES) cycles, and the transition occurs on the final cycle of the phase.
- START_MARK: envelope=1 for START_UNITS, then BIT_SPACE.
- BIT_SPACE: envelope=0 for SPACE_UNITS, then BIT_MARK.
- BIT_MARK:
  - envelope=1 for ONE_UNITS if latched bit[idx]=1, else ZERO_UNITS.
  - If idx<11: increment idx and go to BIT_SPACE. Otherwise go to FRAME_GAP.
- FRAME_GAP: envelope=0 for GAP_UNITS.
  - If repeat < REPEATS-1: increment repeat, set idx=0, go to START_MARK.
  - Otherwise go to IDLE with busy=0 and done=1 on the same edge.
- Frame length in units = START_UNITS + 12·SPACE_UNITS + 12·ZERO_UNITS + popcount(cmd)·(ONE_UNITS−ZERO_UNITS) + GAP_UNITS. With defaults this is 38 + popcount.
- done edge = N + 1 + REPEATS·frame_units·UNIT_CYCLES.
- Carrier:
  - Counter 0..CARRIER_HALF_PERIOD-1; the carrier toggles on wrap.
  - The carrier is forced to 1 and the counter to 0 on the edge that enters any mark, so every mark starts high.
  - ir_out = ir_envelope & carrier, registered together with the envelope so no extra skew is introduced.
- send while busy: ignored; no queueing, and the latched command is unaffected.
- command changing after acceptance: no effect.
- send in the done cycle: accepted, since state is IDLE. Back-to-back transfers are therefore legal.
- reset mid-frame: next edge gives envelope/ir_out=0, busy=0, IDLE; no done pulse.
- Parameter legality: UNIT_CYCLES≥1, CARRIER_HALF_PERIOD≥1, all *_UNITS≥1, REPEATS≥1. Counter widths are derived with $clog2.

Decomposition:
- Shared package:
  - state encodings;
  - the command field positions ANGLE_MSB=11/ANGLE_LSB=7, DIST_MSB=6/DIST_LSB=0, CMD_WIDTH=12;
  - default timing constants, which the rover-side receiver also uses.
- One sub-module, ir_carrier_gen (inputs clock, reset, restart; output carrier), owns the carrier counter.
- The FSM and counters live in the top module.

Test Plan:
- Bench parameters are UNIT_CYCLES=4, CARRIER_HALF_PERIOD=2, REPEATS=1, others default.
- Single frame, command=0x005, send at edge 0 -> ir_envelope high edges 1–16. Next comes a 4-cycle space, then an 8-cycle mark for bit0=1 and a 4-cycle mark for bit1=0. Frame is 40 units, so done pulses at edge 161 and busy falls at edge 161.
- Bit-count extremes -> command=0x000 gives done at edge 153 (38 units); command=0xFFF gives done at edge 201 (50 units). Exactly 13 envelope rising edges per frame in both cases.
- Carrier check -> during every mark ir_out follows the pattern 1,1,0,0 from the first mark cycle; ir_out=0 whenever ir_envelope=0.
- Busy protection -> send 0x0A3, then send 0xFFF at edge 20 with command held at 0xFFF. The serialized bits still decode to 0x0A3, only one done pulse occurs, and a send issued on the done cycle starts a new frame at the next edge.
- Repeats -> with REPEATS=3 and command=0x005, three identical 160-cycle frames are sent back-to-back and done pulses at edge 481 only.
- Mid-frame reset -> reset at edge 50 of a 0x005 transfer gives envelope=0, busy=0, state=IDLE at edge 51 and no done pulse. A subsequent send of 0x005 behaves exactly like the first scenario.
